// File: rtl/mdu_core_if.sv
// mdu_core_if -- issue/result bundle between the EX stage and the MDU.
//
// Handshake: `start` is the issuing side's valid and qualifies op/a/b.
// `!busy` is the MDU's ready. An issue is taken only on a rising clock
// edge where start=1 and busy=0. While busy=1 the issuer keeps start,
// op, a and b stable and re-presents them. The issue is taken at the
// first edge where busy reads 0, which can be the same cycle busy drops.
//
// Signals:
//   start   issuer -> MDU   issue qualifier
//   op      issuer -> MDU   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b    issuer -> MDU   rs / rt operands
//   abort   issuer -> MDU   cancel in-flight op (only with MDU_ABORT_EN)
//   busy    MDU -> issuer   mult/div in flight
//   hi, lo  MDU -> issuer   architectural HI/LO
//   dbg_run MDU -> observer FSM state (1 = RUN)
// Optional feature macro: MDU_ABORT_EN.
interface mdu_core_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MDU_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbg_run;

    modport master (
        input  busy, hi, lo, dbg_run,
        output start, op, a, b
`ifdef MDU_ABORT_EN
        , output abort
`endif
    );

    modport slave (
        output busy, hi, lo, dbg_run,
        input  start, op, a, b
`ifdef MDU_ABORT_EN
        , input abort
`endif
    );
endinterface

// File: rtl/mdu_core.sv
// mdu_core -- multi-cycle multiply/divide unit owning the HI/LO registers.
//
// Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The 64-bit result is
// computed combinationally at issue and latched. After that the unit
// counts off MULT_CYCLES or DIV_CYCLES busy cycles and then commits the
// result to HI/LO. When the divisor is zero, the unit is still busy for
// the full time, but HI/LO keep their old values.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  mdu_core_if.slave (start/op/a/b/[abort] in; busy/hi/lo/dbg_run out)
// Parameters: MULT_CYCLES (>=1), DIV_CYCLES (>=1).
// Optional feature macro: MDU_ABORT_EN. When it is defined, the `abort`
// input cancels an in-flight op and blocks a same-cycle issue.
module mdu_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     rst,
    mdu_core_if.slave bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        res_q;
    logic               dz_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic               abort_w;
`ifdef MDU_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    // ---------------- combinational datapath ----------------
    logic signed [63:0] mul_s_d;
    logic [63:0]        mul_u_d;
    logic [31:0]        abs_a_d, abs_b_d, sdiv_den_d, udiv_den_d;
    logic [31:0]        sq_mag_d, sr_mag_d, sq_d, sr_d, uq_d, ur_d;
    logic [63:0]        res_d;
    logic [CNT_W-1:0]   cyc_d;
    logic               dz_d;

    // The low 64 bits of a 64x64 product of sign-extended operands
    // equal the full signed 32x32 product.
    assign mul_s_d = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign mul_u_d = {32'b0, bus.a} * {32'b0, bus.b};

    // Signed divide on magnitudes. The quotient is negated when the
    // operand signs differ. The remainder follows the dividend sign.
    // 0x80000000 has magnitude 0x80000000, so INT_MIN / -1 gives INT_MIN
    // and remainder 0 without a special case.
    // A zero divisor is replaced by 1 only to keep the divider defined.
    // That result is never committed.
    assign abs_a_d    = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign abs_b_d    = bus.b[31] ? (32'd0 - bus.b) : bus.b;
    assign sdiv_den_d = (bus.b == 32'd0) ? 32'd1 : abs_b_d;
    assign udiv_den_d = (bus.b == 32'd0) ? 32'd1 : bus.b;
    assign sq_mag_d   = abs_a_d / sdiv_den_d;
    assign sr_mag_d   = abs_a_d % sdiv_den_d;
    assign sq_d       = (bus.a[31] ^ bus.b[31]) ? (32'd0 - sq_mag_d) : sq_mag_d;
    assign sr_d       = bus.a[31] ? (32'd0 - sr_mag_d) : sr_mag_d;
    assign uq_d       = bus.a / udiv_den_d;
    assign ur_d       = bus.a % udiv_den_d;

    always_comb begin
        res_d = 64'd0;
        cyc_d = CNT_W'(MULT_CYCLES);
        dz_d  = 1'b0;
        case (bus.op)
            3'd0: res_d = mul_s_d;
            3'd1: res_d = mul_u_d;
            3'd2: begin
                res_d = {sr_d, sq_d};
                cyc_d = CNT_W'(DIV_CYCLES);
                dz_d  = (bus.b == 32'd0);
            end
            3'd3: begin
                res_d = {ur_d, uq_d};
                cyc_d = CNT_W'(DIV_CYCLES);
                dz_d  = (bus.b == 32'd0);
            end
            default: ;
        endcase
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= 64'd0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !abort_w) begin
                        case (bus.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                res_q   <= res_d;
                                dz_q    <= dz_d;
                                cnt_q   <= cyc_d;
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                            3'd4:    hi_q <= bus.a;
                            3'd5:    lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Abort wins over completion. Issues seen here are
                    // ignored, because the issuer holds them until busy drops.
                    if (abort_w) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        if (!dz_q) begin
                            hi_q <= res_q[63:32];
                            lo_q <= res_q[31:0];
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.dbg_run = (state_q == RUN);
endmodule

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives the busy flag that hazard detection uses to stall a following MDU instruction held in ID/EX.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  ID/EX MDU-start qualifier; op/a/b are valid when high.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- abort  input  1  cancel in-flight operation. Present only with MDU_ABORT_EN.
- busy  output  1  registered; high while a mult/div is in flight.
- hi  output  32  HI register, read directly for MFHI.
- lo  output  32  LO register, read directly for MFLO.

Behaviour:
- Reset values (async on rst high): hi=0, lo=0, busy=0, counter=0, latched result=0, state IDLE.
- States: IDLE and RUN.
- IDLE, start=1, op 0-3:
  - Compute the 64-bit result combinationally from a/b and latch it.
  - Load counter with MULT_CYCLES or DIV_CYCLES for the op class.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op 4: hi<=a at this edge; no busy.
- IDLE, start=1, op 5: lo<=a at this edge; no busy.
- IDLE, start=1, op 6-7: no state change.
- RUN:
  - Decrement counter each cycle.
  - At the edge where counter==1: write latched result to hi/lo, clear busy, return to IDLE.
  - Net timing: busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo values are visible in the cycle busy first reads 0.
- start while busy=1 (any op, including MTHI/MTLO): ignored, no effect on state. Hazard detection holds the instruction, so it re-presents start after busy drops.
- Start in the cycle busy drops: accepted normally (back-to-back operations allowed).
- hi/lo outputs hold their old values throughout RUN.
- MULT: signed 64-bit product of a×b; hi=product[63:32], lo=product[31:0].
- MULTU: unsigned 64-bit product; same split as MULT.
- DIV: lo=quotient, hi=remainder.
  - Signed division truncated toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient in lo, unsigned remainder in hi.
- Division by zero (b==0, DIV or DIVU):
  - Busy for DIV_CYCLES as normal.
  - hi/lo left unchanged at completion.
- rst asserted mid-operation: immediate return to reset values. The pending result is discarded.

Optional Feature:
- Macro: MDU_ABORT_EN.
- With the macro defined:
  - abort port exists.
  - abort=1 in RUN: clear busy and counter and return to IDLE at that edge; hi/lo unchanged. Used for exception/flush of the issuing instruction.
  - abort=1 in IDLE suppresses any start in the same cycle (MTHI/MTLO not written).
  - abort has priority over completion in the same cycle.
- Without the macro: no abort port; an operation, once accepted, always completes.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD b=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=100 b=7 → busy 10 cycles; then lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → busy 10 cycles; hi/lo stay 0x11/0x22.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, with MTLO a=0x1234 and start held on every busy cycle:
  - MTLO ignored while busy.
  - Result hi=0xFFFFFFFE, lo=0x00000001.
  - In the cycle busy drops, the held MTLO is accepted; lo=0x1234 next cycle.
- rst pulsed on cycle 3 of a DIV → hi=lo=0 and busy=0 immediately.
- With MDU_ABORT_EN: abort on cycle 2 of MULT → busy 0 next edge; hi/lo unchanged.
